// File: rtl/pinswap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pinswap_pkg
// Description : Shared types and constants for the pin-swap stimulus
//               checker. Holds the FSM state type, the MISR constants, the
//               LFSR tap positions and the golden model of the pin-swap test
//               netlist. The testbench imports the same golden model.
// Revision    : 1.0 - initial release
// ============================================================================
package pinswap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FIN     = 2'd3
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_INIT = 16'hFFFF;

    // Feedback taps of the 6-bit Fibonacci LFSR (maximal length, period 63).
    localparam int LFSR_TAP_A = 5;
    localparam int LFSR_TAP_B = 4;

    // Golden netlist: y1 = ~(a1&a2) & a3, y2 = a4&a5&a6&y1.
    // Bit 0 of a is a1, bit 0 of the result is y1.
    function automatic logic [1:0] exp_y(input logic [5:0] a);
        logic w_y1;
        w_y1 = ~(a[0] & a[1]) & a[2];
        return {a[3] & a[4] & a[5] & w_y1, w_y1};
    endfunction

    function automatic logic [5:0] lfsr_next(input logic [5:0] v);
        return {v[4:0], v[LFSR_TAP_A] ^ v[LFSR_TAP_B]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pinswap_misr16.sv
`default_nettype none
// ============================================================================
// Module      : pinswap_misr16
// Description : 16-bit MISR (CRC-16/CCITT polynomial) folding in the 2-bit
//               netlist response once per enabled cycle.
// Ports       : clk, rst_n (async, active-low)
//               clear  - reload MISR_INIT (has priority over enable)
//               enable - shift in data this cycle
//               data   - 2-bit captured response {y2,y1}
//               sig    - current signature
// Revision    : 1.0 - initial release
// ============================================================================
module pinswap_misr16
    import pinswap_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [1:0]  data,
    output logic [15:0] sig
);

    logic [15:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= MISR_INIT;
        end else if (clear) begin
            r_sig <= MISR_INIT;
        end else if (enable) begin
            r_sig <= ({r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000))
                     ^ {14'b0, data};
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/pinswap_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : pinswap_stim_checker
// Description : Drives LFSR vectors into the pin-swap test netlist, waits a
//               programmable settle time, captures y1/y2, checks them against
//               the golden model and accumulates an error count and MISR.
// Ports       : clk, rst_n (async, active-low)
//               start     - run request, sampled only in IDLE
//               a_out     - stimulus {a6..a1}
//               y_in      - netlist response {y2,y1}
//               busy      - run in progress
//               done      - one-cycle end-of-run pulse
//               pass      - last run had no mismatches
//               err_count - mismatching vectors, saturating at 255
//               signature - MISR of captured responses
// Revision    : 1.0 - initial release
// ============================================================================
module pinswap_stim_checker
    import pinswap_pkg::*;
#(
    parameter int          NUM_VECTORS   = 64,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [5:0]  LFSR_SEED     = 6'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [5:0]  a_out,
    input  logic [1:0]  y_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] signature
);

    localparam int               CNT_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_reload = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [9:0]       c_last_idx   = 10'(NUM_VECTORS - 1);
    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [5:0]       c_seed       = (LFSR_SEED == 6'h00) ? 6'h01 : LFSR_SEED;

    state_t           r_state;
    logic [9:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_a;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [7:0]       r_err;

    logic             w_launch;
    logic             w_capture;
    logic             w_mismatch;

    assign w_launch   = (r_state == ST_IDLE) && start;
    assign w_capture  = (r_state == ST_CAPTURE);
    assign w_mismatch = (y_in != exp_y(r_a));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 10'd0;
            r_cnt   <= '0;
            r_a     <= 6'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= c_seed;
                        r_idx   <= 10'd0;
                        r_cnt   <= c_cnt_reload;
                        r_err   <= 8'h00;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (w_mismatch && (r_err != 8'hFF)) begin
                        r_err <= r_err + 8'd1;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_idx   <= r_idx + 10'd1;
                        r_a     <= lfsr_next(r_a);
                        r_cnt   <= c_cnt_reload;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_FIN: begin
                    // r_err already includes the final capture here.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_pass  <= (r_err == 8'h00);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    pinswap_misr16 u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_launch),
        .enable (w_capture),
        .data   (y_in),
        .sig    (signature)
    );

    assign a_out     = r_a;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pinswap_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pinswap_stim_checker
// Description : Self-checking bench for pinswap_stim_checker. Three checker
//               instances with different parameters share one netlist
//               responder; a timeline-based model of the selected instance
//               is compared against its outputs on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pinswap_stim_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [1:0]  y_drv;

    logic [5:0]  a_o [3];
    logic        bz  [3];
    logic        dn  [3];
    logic        ps  [3];
    logic [7:0]  ec  [3];
    logic [15:0] sg  [3];

    always #5 clk = ~clk;

    pinswap_stim_checker #(.NUM_VECTORS(64), .SETTLE_CYCLES(1), .LFSR_SEED(6'h01)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_out(a_o[0]), .y_in(y_drv),
        .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_count(ec[0]), .signature(sg[0]));
    pinswap_stim_checker #(.NUM_VECTORS(1), .SETTLE_CYCLES(1), .LFSR_SEED(6'h04)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_out(a_o[1]), .y_in(y_drv),
        .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_count(ec[1]), .signature(sg[1]));
    pinswap_stim_checker #(.NUM_VECTORS(300), .SETTLE_CYCLES(2), .LFSR_SEED(6'h00)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_out(a_o[2]), .y_in(y_drv),
        .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_count(ec[2]), .signature(sg[2]));

    // Per-instance parameters as seen by the model.
    int          p_n    [3] = '{64, 1, 300};
    int          p_s    [3] = '{1, 1, 2};
    int          p_seed [3] = '{1, 4, 0};

    int          sel = 0;
    int          mode = 0;        // 0 ideal, 1 inverted, 2 constant, 3 glitchy
    logic [1:0]  y_const = 2'b00;
    logic [1:0]  noise = 2'b00;
    logic        glitch_en = 1'b0;

    logic [5:0]  s_aout;
    logic        s_busy, s_done, s_pass;
    logic [7:0]  s_err;
    logic [15:0] s_sig;

    int n_cmp = 0;
    int n_bad = 0;

    // Ideal pin-swap netlist, written independently of the package model.
    function automatic logic [1:0] ideal(input logic [5:0] a);
        logic y1;
        y1 = a[2] && !(a[0] && a[1]);
        return {y1 && (a[5:3] == 3'b111), y1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always_comb begin
        s_aout = a_o[sel];
        s_busy = bz[sel];
        s_done = dn[sel];
        s_pass = ps[sel];
        s_err  = ec[sel];
        s_sig  = sg[sel];
    end

    always_comb begin
        case (mode)
            0:       y_drv = ideal(s_aout);
            1:       y_drv = ~ideal(s_aout);
            2:       y_drv = y_const;
            default: y_drv = glitch_en ? noise : ideal(s_aout);
        endcase
    end

    // ---------------- behavioural model ----------------
    logic        m_run = 1'b0;
    int          m_t = 0;
    logic [5:0]  m_vec [1024];
    logic [5:0]  m_aout = 6'h00;
    logic        m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0;
    int          m_err = 0;
    logic [15:0] m_sig = 16'hFFFF;
    logic        m_chk = 1'b0;
    logic [1:0]  y_pre = 2'b00;
    logic [2:0]  st_pre = 3'b000;

    // Snapshot of the inputs just before each rising edge.
    initial forever begin
        @(negedge clk);
        #4;
        y_pre  = y_drv;
        st_pre = start_v;
    end

    // Glitch noise is only allowed when the next edge is not a capture edge.
    initial forever begin
        @(negedge clk);
        noise     = 2'($urandom_range(0, 3));
        glitch_en = (mode == 3) && m_run && (((m_t + 1) % (p_s[sel] + 1)) != 0);
    end

    // Edge t after the start edge: capture of vector k happens at edge
    // (k+1)*(S+1); done rises at edge N*(S+1)+1.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 1'b0; m_aout = 6'h00; m_busy = 1'b0; m_done = 1'b0;
            m_pass = 1'b0; m_err = 0; m_sig = 16'hFFFF;
        end else if (!m_run) begin
            m_done = 1'b0;
            if (st_pre[sel]) begin
                int v;
                v = (p_seed[sel] == 0) ? 1 : p_seed[sel];
                for (int i = 0; i < p_n[sel]; i++) begin
                    m_vec[i] = 6'(v);
                    v = ((v * 2) % 64) + (((v / 32) + (v / 16)) % 2);
                end
                m_run = 1'b1; m_t = 0; m_aout = m_vec[0]; m_err = 0;
                m_sig = 16'hFFFF; m_pass = 1'b0; m_busy = 1'b1;
            end
        end else begin
            m_t++;
            if (m_t == p_n[sel] * (p_s[sel] + 1) + 1) begin
                m_done = 1'b1; m_busy = 1'b0; m_pass = (m_err == 0); m_run = 1'b0;
            end else if ((m_t % (p_s[sel] + 1)) == 0) begin
                int k;
                k = m_t / (p_s[sel] + 1) - 1;
                if (y_pre != ideal(m_vec[k]) && m_err < 255) m_err++;
                m_sig = ((m_sig << 1) ^ (m_sig >= 16'h8000 ? 16'h1021 : 16'h0000))
                        ^ {14'b0, y_pre};
                if (k < p_n[sel] - 1) m_aout = m_vec[k + 1];
            end
        end
    end

    // Single compare process, every cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        if (m_chk) begin
            chk("a_out", 32'(s_aout), 32'(m_aout));
            chk("busy", 32'(s_busy), 32'(m_busy));
            chk("done", 32'(s_done), 32'(m_done));
            chk("pass", 32'(s_pass), 32'(m_pass));
            chk("err_count", 32'(s_err), 32'(m_err));
            chk("signature", 32'(s_sig), 32'(m_sig));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic switch_to(input int s);
        @(negedge clk);
        rst_n = 1'b0;
        sel   = s;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_case(input string nm, input int exp_edge, input bit spam,
                            input int probe_edge, input logic [5:0] probe_val,
                            input logic [5:0] first_val, output int dones);
        int edges;
        int fin_edge;
        fin_edge = exp_edge - 1;
        dones = 0;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[sel] = 1'b0;
        chk({nm, "_first_vec"}, 32'(s_aout), 32'(first_val));
        edges = 0;
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == probe_edge) chk({nm, "_probe_vec"}, 32'(s_aout), 32'(probe_val));
            if (s_done) begin
                dones++;
                break;
            end
            if (edges >= exp_edge + 20) break;
            if (spam) start_v[sel] = (edges == fin_edge) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        start_v[sel] = 1'b0;
        chk({nm, "_done_edge"}, 32'(edges), 32'(exp_edge));
        repeat (3) begin
            @(negedge clk);
            if (s_done) dones++;
        end
    endtask

    initial begin
        int d;
        rst_n   = 1'b0;
        start_v = 3'b000;
        repeat (3) @(negedge clk);
        m_chk = 1'b1;
        chk("reset_a_out", 32'(s_aout), 32'h0);
        chk("reset_sig", 32'(s_sig), 32'hFFFF);
        chk("reset_busy", 32'(s_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Golden loopback on the 64-vector instance.
        mode = 0;
        run_case("golden", 129, 1'b0, -1, 6'h00, 6'h01, d);
        chk("golden_err", 32'(s_err), 32'd0);
        chk("golden_pass", 32'(s_pass), 32'd1);

        // start hammered during the run and in FIN, inverted responses.
        mode = 1;
        run_case("spam", 129, 1'b1, -1, 6'h00, 6'h01, d);
        chk("spam_done_pulses", 32'(d), 32'd1);
        chk("spam_err", 32'(s_err), 32'd64);
        chk("spam_pass", 32'(s_pass), 32'd0);
        mode = 0;
        run_case("rerun", 129, 1'b0, -1, 6'h00, 6'h01, d);
        chk("rerun_err_cleared", 32'(s_err), 32'd0);

        // Reset in the settle cycle of vector 10, then a clean run.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_a_out", 32'(s_aout), 32'h0);
        chk("abort_busy", 32'(s_busy), 32'h0);
        chk("abort_err", 32'(s_err), 32'h0);
        chk("abort_sig", 32'(s_sig), 32'hFFFF);
        d = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_done) d++;
        end
        chk("abort_no_done", 32'(d), 32'd0);
        rst_n = 1'b1;
        run_case("after_abort", 129, 1'b0, -1, 6'h00, 6'h01, d);
        chk("after_abort_pass", 32'(s_pass), 32'd1);

        // Single vector, seed 4.
        switch_to(1);
        mode = 2;
        y_const = 2'b01;
        run_case("single_ok", 3, 1'b0, -1, 6'h00, 6'h04, d);
        chk("single_ok_sig", 32'(s_sig), 32'hEFDE);
        chk("single_ok_err", 32'(s_err), 32'd0);
        chk("single_ok_pass", 32'(s_pass), 32'd1);
        y_const = 2'b00;
        run_case("single_bad", 3, 1'b0, -1, 6'h00, 6'h04, d);
        chk("single_bad_sig", 32'(s_sig), 32'hEFDF);
        chk("single_bad_err", 32'(s_err), 32'd1);
        chk("single_bad_pass", 32'(s_pass), 32'd0);

        // Seed 0, 300 vectors, settle 2: saturation and LFSR wrap.
        switch_to(2);
        mode = 1;
        run_case("saturate", 901, 1'b0, 189, 6'h01, 6'h01, d);
        chk("saturate_err", 32'(s_err), 32'd255);
        chk("saturate_pass", 32'(s_pass), 32'd0);

        // Random y_in glitches away from the capture edges must not matter.
        mode = 3;
        run_case("glitch", 901, 1'b0, 189, 6'h01, 6'h01, d);
        chk("glitch_err", 32'(s_err), 32'd0);
        chk("glitch_pass", 32'(s_pass), 32'd1);

        m_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
